// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between pll_lock_supervisor (master) and the PLL wrapper side (slave).
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             force_relock;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             lock_ok;
    logic             lock_fail;
    logic [CNT_W-1:0] relock_count;

    modport master (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output lock_fail,
        output relock_count
    );

    modport slave (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  lock_fail,
        input  relock_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst_n.
// Optional macro PLL_LOCK_DEGLITCH_EN: lock loss in RUN needs DEGLITCH_CYCLES consecutive low cycles.
module pll_lock_supervisor #(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int STABLE_CYCLES   = 1024,
    parameter int MAX_RETRIES     = 4,
    parameter int DEGLITCH_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master bus
);
    localparam int T_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX = (T_AB > STABLE_CYCLES) ? T_AB : STABLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [RW-1:0]    r_retries;
    logic [1:0]       r_sync;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_lock_ok;
    logic             r_lock_fail;
    logic [CNT_W-1:0] r_relock_count;
    logic             w_lock_s;
    logic             w_loss;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.pll_locked};
        end
    end

    assign w_lock_s = r_sync[1];

`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
    localparam logic [DW-1:0] LOW_LAST = DW'(DEGLITCH_CYCLES - 1);

    logic [DW-1:0] r_low_run;

    assign w_loss = !w_lock_s && (r_low_run == LOW_LAST);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_run <= '0;
        end else if ((r_state != S_RUN) || w_lock_s) begin
            r_low_run <= '0;
        end else if (!w_loss) begin
            r_low_run <= r_low_run + 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_loss       = !w_lock_s;
    assign w_unused_cfg = (DEGLITCH_CYCLES > 0);
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_RESET_PLL;
            r_timer        <= '0;
            r_retries      <= '0;
            r_pll_rst      <= 1'b1;
            r_sys_rst_n    <= 1'b0;
            r_lock_ok      <= 1'b0;
            r_lock_fail    <= 1'b0;
            r_relock_count <= '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == RST_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (bus.force_relock) begin
                        r_state   <= S_RESET_PLL;
                        r_pll_rst <= 1'b1;
                        r_timer   <= '0;
                        r_retries <= '0;
                    end else if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_timer <= '0;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_timer   <= '0;
                        r_pll_rst <= 1'b1;
                        r_retries <= r_retries + 1'b1;
                        if (r_retries == RETRY_LAST) begin
                            r_state     <= S_FAIL;
                            r_lock_fail <= 1'b1;
                        end else begin
                            r_state <= S_RESET_PLL;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // A drop while qualifying is not a timeout, so no retry is charged
                S_STABLE: begin
                    if (bus.force_relock) begin
                        r_state   <= S_RESET_PLL;
                        r_pll_rst <= 1'b1;
                        r_timer   <= '0;
                        r_retries <= '0;
                    end else if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_timer <= '0;
                    end else if (r_timer == STABLE_LAST) begin
                        r_state     <= S_RUN;
                        r_timer     <= '0;
                        r_retries   <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_lock_ok   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // Lock loss wins over a coincident force_relock so it is still counted
                S_RUN: begin
                    if (w_loss || bus.force_relock) begin
                        r_state     <= S_RESET_PLL;
                        r_pll_rst   <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_lock_ok   <= 1'b0;
                        r_timer     <= '0;
                        if (w_loss) begin
                            if (r_relock_count != {CNT_W{1'b1}}) begin
                                r_relock_count <= r_relock_count + 1'b1;
                            end
                        end else begin
                            r_retries <= '0;
                        end
                    end
                end

                S_FAIL: begin
                    if (bus.force_relock) begin
                        r_state     <= S_RESET_PLL;
                        r_lock_fail <= 1'b0;
                        r_retries   <= '0;
                        r_timer     <= '0;
                    end
                end

                default: begin
                    r_state     <= S_RESET_PLL;
                    r_pll_rst   <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_lock_ok   <= 1'b0;
                    r_timer     <= '0;
                end
            endcase
        end
    end

    assign bus.pll_rst      = r_pll_rst;
    assign bus.sys_rst_n    = r_sys_rst_n;
    assign bus.lock_ok      = r_lock_ok;
    assign bus.lock_fail    = r_lock_fail;
    assign bus.relock_count = r_relock_count;
endmodule
